wb_slave_register: RTL and testbench
====================================

# wb_slave_register

Single-word Wishbone B4 slave register holding one DATA_WIDTH-bit value with byte-lane (granule) select. It answers both classic and pipelined single reads and writes, plus read-modify-write cycles, at one fixed word address, and signals ERR for any other address. It is used as a leaf peripheral on a Wishbone interconnect and as the reference slave for bus-master bring-up.

## Interface
- ADDR_WIDTH, 16, width of adr_i.
- DATA_WIDTH, 32, width of the data bus and of the stored register.
- GRANULE, 8, bits per select lane; DATA_WIDTH must be a multiple of GRANULE.
- REG_ADDR, 0, the value of adr_i that selects the register.
- SEL_WIDTH (derived, not overridable), DATA_WIDTH/GRANULE.

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- adr_i  in  ADDR_WIDTH  word address.
- dat_i  in  DATA_WIDTH  write data from master.
- dat_o  out  DATA_WIDTH  read data to master.
- sel_i  in  SEL_WIDTH  lane select; bit n covers dat bits [n*GRANULE +: GRANULE].
- we_i  in  1  1 = write, 0 = read.
- cyc_i  in  1  bus cycle in progress.
- stb_i  in  1  strobe; qualifies a request.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination.

## Operation
- Reset values: register = 0, dat_o = 0, ack_o = 0, err_o = 0.
- Request accepted on a rising edge where cyc_i & stb_i & !ack_o & !err_o are all true. All other edges accept no request.
- Address hit (adr_i == REG_ADDR) produces ACK. Address miss produces ERR, and the register and dat_o are left unchanged.
- Write hit: for each n with sel_i[n]=1, lane n of the register takes lane n of dat_i. Lanes with sel_i[n]=0 keep their value. sel_i = 0 still ACKs and changes nothing.
- Read hit: dat_o lane n = register lane n if sel_i[n]=1, else 0. dat_o then holds that value until the next accepted read hit.
- ack_o and err_o are never asserted together.
- Read-modify-write: cyc_i stays high across a read request and a following write request. Each request is handled independently as above. The read returns the pre-write value.
- Pipelined mode: stb_i is high for only one edge, and adr/sel/dat/we may go to X afterwards. The response relies only on values sampled at the accepting edge.
- Classic mode: the master holds stb_i until it sees ack/err. The "!ack_o & !err_o" term prevents a second acceptance on the edge that ends the ACK cycle.

## Timing
- Latency is one cycle. ack_o or err_o rises on the accepting edge and is high for exactly one clock, then falls on the next edge unconditionally.
- Write data reaches the register on the accepting edge. A read accepted on any later edge returns the new value.
- dat_o is updated on the same edge that raises ack_o, and is valid throughout the ACK cycle.
- If cyc_i is low on the edge following acceptance, ack_o/err_o still fall on that edge. No state is rolled back.
- Back-to-back requests are possible no faster than every second cycle: accept, ack, accept.
- Asserting rst_i mid-cycle immediately clears ack_o, err_o, dat_o and the register, without waiting for a clock. The in-flight request is dropped.
- There is no stall output. The slave is always ready.

## Test plan
- Reset, then classic read at addr 0x0000 with sel 0xF -> ACK after 1 cycle, dat_o 0x00000000.
- Classic write 0xDEADBEEF sel 0xF at 0x0000, then read sel 0xF -> ACK both, read 0xDEADBEEF. Then write 0x11223344 sel 0x5 and read sel 0xF -> 0xDE22BE44.
- Read with sel 0x6 after the above -> 0x0022BE00, ACK.
- Classic and pipelined write/read to 0x0004 -> ERR, each for exactly one cycle with no ack_o. A following read of 0x0000 returns the unchanged value.
- Pipelined write 0xCAFEF00D (stb one cycle, bus then X), then pipelined read -> ACK one cycle after each strobe, read 0xCAFEF00D.
- RMW on 0x0000: read phase returns 0xCAFEF00D. Write 0x12345678 sel 0xF, then a read returns 0x12345678. Asserting rst_i mid-ACK clears ack_o at once and a subsequent read returns 0.

Source files
------------

// File: rtl/wb_slave_register.sv
// rtl/wb_slave_register.sv - single-word Wishbone B4 slave register with lane select
// Classic and pipelined single accesses, one-cycle ACK on hit, ERR on any other address.
module wb_slave_register #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int GRANULE    = 8,
   parameter logic [ADDR_WIDTH-1:0] REG_ADDR = '0,
   localparam int SEL_WIDTH = DATA_WIDTH / GRANULE
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] adr_i,
   input  logic [DATA_WIDTH-1:0] dat_i,
   output logic [DATA_WIDTH-1:0] dat_o,
   input  logic [SEL_WIDTH-1:0]  sel_i,
   input  logic                  we_i,
   input  logic                  cyc_i,
   input  logic                  stb_i,
   output logic                  ack_o,
   output logic                  err_o
);

   logic [DATA_WIDTH-1:0] data_reg;
   logic [DATA_WIDTH-1:0] lane_mask;
   logic                  accept;
   logic                  hit;

   // Blocking on a pending ack/err keeps a held classic strobe from being taken twice.
   assign accept = cyc_i & stb_i & ~ack_o & ~err_o;
   assign hit    = (adr_i == REG_ADDR);

   always_comb begin
      lane_mask = '0;
      for (int n = 0; n < SEL_WIDTH; n++)
         lane_mask[n*GRANULE +: GRANULE] = {GRANULE{sel_i[n]}};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_reg <= '0;
         dat_o    <= '0;
         ack_o    <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         ack_o <= accept & hit;
         err_o <= accept & ~hit;
         if (accept && hit && we_i)
            data_reg <= (data_reg & ~lane_mask) | (dat_i & lane_mask);
         if (accept && hit && !we_i)
            dat_o <= data_reg & lane_mask;
      end
   end

endmodule

// File: tb/tb_wb_slave_register.sv
// tb/tb_wb_slave_register.sv - self-checking bench for wb_slave_register
// Directed plan cases followed by randomized traffic against a lane-level reference model.
module tb_wb_slave_register;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] adr = '0;
   logic [31:0] wdat = '0;
   logic [31:0] rdat;
   logic [3:0]  sel = '0;
   logic        we = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        ack;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_reg = '0;
   logic [31:0] model_dat = '0;

   wb_slave_register dut (
      .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .dat_o(rdat),
      .sel_i(sel), .we_i(we), .cyc_i(cyc), .stb_i(stb), .ack_o(ack), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lane_pick(input logic [31:0] val, input logic [3:0] s);
      logic [31:0] r = '0;
      for (int n = 0; n < 4; n++)
         if (s[n]) r[n*8 +: 8] = val[n*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] s);
      logic [31:0] r = old;
      for (int n = 0; n < 4; n++)
         if (s[n]) r[n*8 +: 8] = nw[n*8 +: 8];
      return r;
   endfunction

   // One single access; pipelined drops strobe and floats the bus after the accepting edge,
   // classic holds strobe through the edge that ends the response.
   task automatic xfer(input bit pipelined, input bit w, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] s, input bit hold_cyc);
      bit hit;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      @(posedge clk); #1;
      hit = (a == 16'h0000);
      if (hit && w) model_reg = lane_merge(model_reg, d, s);
      if (hit && !w) model_dat = lane_pick(model_reg, s);
      check_value("ack_resp", {31'b0, ack}, {31'b0, hit});
      check_value("err_resp", {31'b0, err}, {31'b0, !hit});
      check_value("dat_resp", rdat, model_dat);
      if (pipelined) begin
         @(negedge clk);
         stb = 1'b0; we = 1'bx; adr = 'x; wdat = 'x; sel = 'x;
      end
      @(posedge clk); #1;
      check_value("ack_fall", {31'b0, ack}, 32'd0);
      check_value("err_fall", {31'b0, err}, 32'd0);
      check_value("dat_hold", rdat, model_dat);
      stb = 1'b0;
      if (!hold_cyc) cyc = 1'b0;
   endtask

   initial begin
      #1;
      check_value("rst_ack", {31'b0, ack}, 32'd0);
      check_value("rst_err", {31'b0, err}, 32'd0);
      check_value("rst_dat", rdat, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;

      xfer(0, 0, 16'h0000, 32'h0, 4'hF, 0);
      xfer(0, 1, 16'h0000, 32'hDEADBEEF, 4'hF, 0);
      xfer(0, 0, 16'h0000, 32'h0, 4'hF, 0);
      check_value("plan_read1", rdat, 32'hDEADBEEF);
      xfer(0, 1, 16'h0000, 32'h11223344, 4'h5, 0);
      xfer(0, 0, 16'h0000, 32'h0, 4'hF, 0);
      check_value("plan_read2", rdat, 32'hDE22BE44);
      xfer(0, 0, 16'h0000, 32'h0, 4'h6, 0);
      check_value("plan_sel6", rdat, 32'h0022BE00);

      xfer(0, 1, 16'h0004, 32'hFFFFFFFF, 4'hF, 0);
      xfer(0, 0, 16'h0004, 32'h0, 4'hF, 0);
      xfer(1, 1, 16'h0004, 32'hFFFFFFFF, 4'hF, 0);
      xfer(1, 0, 16'h0004, 32'h0, 4'hF, 0);
      xfer(0, 0, 16'h0000, 32'h0, 4'hF, 0);
      check_value("err_unchanged", rdat, 32'hDE22BE44);
      xfer(0, 1, 16'h0000, 32'hAAAAAAAA, 4'h0, 0);
      xfer(0, 0, 16'h0000, 32'h0, 4'hF, 0);
      check_value("sel0_write", rdat, 32'hDE22BE44);

      xfer(1, 1, 16'h0000, 32'hCAFEF00D, 4'hF, 0);
      xfer(1, 0, 16'h0000, 32'h0, 4'hF, 0);
      check_value("pipe_read", rdat, 32'hCAFEF00D);

      xfer(0, 0, 16'h0000, 32'h0, 4'hF, 1);
      check_value("rmw_read", rdat, 32'hCAFEF00D);
      xfer(0, 1, 16'h0000, 32'h12345678, 4'hF, 0);
      xfer(0, 0, 16'h0000, 32'h0, 4'hF, 0);
      check_value("rmw_after", rdat, 32'h12345678);

      // Reset landing inside the ACK cycle must clear outputs without a clock edge.
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0000; sel = 4'hF;
      @(posedge clk); #1;
      check_value("pre_rst_ack", {31'b0, ack}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check_value("mid_rst_ack", {31'b0, ack}, 32'd0);
      check_value("mid_rst_dat", rdat, 32'd0);
      stb = 1'b0; cyc = 1'b0;
      model_reg = '0; model_dat = '0;
      @(negedge clk); rst = 1'b0;
      xfer(0, 0, 16'h0000, 32'h0, 4'hF, 0);
      check_value("post_rst_read", rdat, 32'd0);

      for (int i = 0; i < 300; i++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
         xfer($urandom_range(0, 1), $urandom_range(0, 1), a, $urandom,
              4'($urandom), $urandom_range(0, 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
